skid_register_nb: RTL

//  Parametrised pipeline register with a val/rdy handshake on both sides and
//  a 2-entry skid buffer; successor to the fixed 16-bit enable register.

---
 rtl/skid_register_nb.sv | 107 ++++++++++
 1 files changed

// File: rtl/skid_register_nb.sv
// Two-entry skid register with val/rdy on both sides. The head entry is always
// in main_q, and in_rdy is decoded from registered state only, never from out_rdy.
module skid_register_nb #(
    parameter int unsigned        p_nbits   = 16,
    parameter logic [p_nbits-1:0] p_rst_val = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [p_nbits-1:0] in_msg,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out_msg,
    output logic [1:0]         count
);

    // state    | meaning
    // ST_EMPTY | nothing buffered, out_val low
    // ST_ONE   | head in main_q, skid_q unused
    // ST_TWO   | head in main_q, next message in skid_q, in_rdy low
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [p_nbits-1:0] main_q;
    logic [p_nbits-1:0] skid_q;
    logic               load_main_in;
    logic               load_main_skid;
    logic               load_skid;
    logic               in_fire;
    logic               out_fire;

    assign in_rdy   = rst & ~flush & (state_q != ST_TWO);
    assign out_val  = (state_q != ST_EMPTY);
    assign out_msg  = main_q;
    assign count    = state_q;
    assign in_fire  = in_val & in_rdy;
    assign out_fire = out_val & out_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d      = ST_ONE;
                        load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        state_d   = ST_TWO;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_d        = ST_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Data registers are deliberately left untouched by flush and dequeue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q <= p_rst_val;
            skid_q <= p_rst_val;
        end else begin
            if (load_main_in) begin
                main_q <= in_msg;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_msg;
            end
        end
    end

endmodule
